// File: rtl/output_drain.sv
// Output drain: buffers tagged samples from the conv controller
// and drains them over a valid/ready result interface.
module output_drain #(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int PIPE_SLACK         = 6,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic                  output_valid,
  input  logic [DATA_WIDTH-1:0] output_data,
  input  logic [31:0]           output_x,
  input  logic [31:0]           output_y,
  input  logic [31:0]           output_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [31:0]           out_x,
  output logic [31:0]           out_y,
  output logic [31:0]           out_ch,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  overflow_err,
  output logic                  stray_err,
  output logic [31:0]           out_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TOTAL = 32'(FEATURE_MAP_WIDTH
    * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
  localparam logic [AW:0] STALL_TH =
    (AW+1)'(FIFO_DEPTH - PIPE_SLACK);

  typedef enum logic [1:0] {
    IDLE, RUN, FLUSH, DONE
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           x;
    logic [31:0]           y;
    logic [31:0]           ch;
  } entry_t;

  state_e      state_q, state_d;
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [AW:0] occ;
  logic [31:0] acc_q, acc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        stray_q, stray_d;

  entry_t mem_q [FIFO_DEPTH];
  entry_t head;
  entry_t wr_entry;

  logic empty, full;
  logic pop, push_try, push, drop;

  // Occupancy, flags and the combinational head read.
  always_comb begin
    occ      = wr_q - rd_q;
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW-1:0] == rd_q[AW-1:0])
            && (wr_q[AW] != rd_q[AW]);
    pop      = !empty && out_ready;
    push_try = (state_q == RUN) && output_valid;
    push     = push_try && (!full || pop);
    drop     = push_try && full && !pop;
    head     = mem_q[rd_q[AW-1:0]];
    wr_entry = '{data: output_data, x: output_x,
                 y: output_y, ch: output_ch};
  end

  // Layer FSM, counters and sticky error flags.
  always_comb begin
    state_d = state_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    acc_d   = acc_q;
    cnt_d   = pop ? cnt_q + 32'd1 : cnt_q;
    ovf_d   = ovf_q | drop;
    stray_d = stray_q
            | (output_valid && (state_q != RUN));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          stray_d = 1'b0;
        end
      end
      RUN: begin
        if (push_try) begin
          acc_d = acc_q + 32'd1;
          if (acc_q + 32'd1 == TOTAL) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (empty && !pop) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      stray_q <= stray_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wr_entry;
  end

  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : head.data;
  assign out_x        = empty ? '0 : head.x;
  assign out_y        = empty ? '0 : head.y;
  assign out_ch       = empty ? '0 : head.ch;
  assign stall_req    = (occ >= STALL_TH);
  assign busy         = (state_q != IDLE);
  assign layer_done   = (state_q == DONE);
  assign overflow_err = ovf_q;
  assign stray_err    = stray_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: directed layers with a
// queue scoreboard and an independent pop monitor.
module tb_output_drain;

  localparam int DW  = 32;
  localparam int FD  = 8;
  localparam int PS  = 6;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int C   = 4;
  localparam int TOT = W * H * C;

  logic          clk;
  logic          rst_in;
  logic          start;
  logic          output_valid;
  logic [DW-1:0] output_data;
  logic [31:0]   output_x, output_y, output_ch;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_x, out_y, out_ch;
  logic          stall_req, busy, layer_done;
  logic          overflow_err, stray_err;
  logic [31:0]   out_count;

  output_drain #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .PIPE_SLACK(PS),
    .FEATURE_MAP_WIDTH(W),
    .FEATURE_MAP_HEIGHT(H),
    .OUTPUT_NB_CHANNELS(C)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .start(start),
    .output_valid(output_valid),
    .output_data(output_data),
    .output_x(output_x),
    .output_y(output_y),
    .output_ch(output_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_x(out_x),
    .out_y(out_y),
    .out_ch(out_ch),
    .stall_req(stall_req),
    .busy(busy),
    .layer_done(layer_done),
    .overflow_err(overflow_err),
    .stray_err(stray_err),
    .out_count(out_count)
  );

  typedef struct {
    logic [127:0] v;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_vec;
  int           n_err;
  int           cyc;
  int           pops;
  int           done_cnt;
  int           exp_cnt;
  bit           lat_chk;
  bit           hold;
  logic [127:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present sample i; if it should be accepted, queue it.
  task automatic put(int i, int tag, bit acc);
    exp_t e;
    output_valid = 1'b1;
    output_data  = 32'(tag * 256 + i);
    output_x     = 32'(i % W);
    output_y     = 32'((i / W) % H);
    output_ch    = 32'(i / (W * H));
    if (acc) begin
      e.v   = {output_data, output_x, output_y, output_ch};
      e.cyc = cyc;
      sb.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic wait_done(string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!layer_done && k < 500);
    chk({nm, "_done"}, 128'(layer_done), 128'(1));
    chk({nm, "_count"}, 128'(out_count), 128'(exp_cnt));
    chk({nm, "_sb_empty"}, 128'(sb.size()), 128'(0));
    step();
  endtask

  task automatic run_layer(int tag);
    out_ready = 1'b1;
    for (int i = 0; i < TOT; i++) begin
      put(i, tag, 1'b1);
      step();
    end
    output_valid = 1'b0;
  endtask

  // Monitor: checks every pop against the scoreboard.
  always @(negedge clk) begin
    logic [127:0] cur;
    exp_t         e;
    cur = {out_data, out_x, out_y, out_ch};
    if (rst_in) begin
      hold = 1'b0;
    end else begin
      if (hold && out_valid)
        chk("hold_stable", cur, held);
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          chk("pop_unexpected", cur, 128'(0));
          n_err += (cur == 0) ? 1 : 0;
        end else begin
          e = sb.pop_front();
          chk("pop_data", cur, e.v);
          if (lat_chk)
            chk("latency", 128'(cyc), 128'(e.cyc + 1));
        end
      end
      hold = out_valid && !out_ready;
      held = cur;
    end
    if (layer_done) done_cnt++;
  end

  initial begin
    int i;
    int k;
    int p0;
    n_vec = 0; n_err = 0; pops = 0; done_cnt = 0;
    exp_cnt = 0; lat_chk = 1'b0; hold = 1'b0;
    rst_in = 1'b1; start = 1'b0; output_valid = 1'b0;
    output_data = '0; output_x = '0; output_y = '0;
    output_ch = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_stall", 128'(stall_req), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(layer_done), 128'(0));
    chk("rst_errs", 128'({overflow_err, stray_err}), 128'(0));
    chk("rst_count", 128'(out_count), 128'(0));
    chk("rst_head", {out_data, out_x, out_y, out_ch}, 128'(0));
    rst_in = 1'b0;
    step();

    // Basic layer, ready held high, latency checked.
    do_start();
    chk("basic_busy", 128'(busy), 128'(1));
    lat_chk = 1'b1;
    run_layer(1);
    wait_done("basic");
    lat_chk = 1'b0;
    chk("basic_errs", 128'({overflow_err, stray_err}), 128'(0));
    repeat (2) step();
    chk("basic_done_once", 128'(done_cnt), 128'(1));

    // Backpressure, overflow and full push+pop.
    do_start();
    out_ready = 1'b0;
    for (i = 0; i < FD; i++) begin
      put(i, 2, 1'b1);
      step();
      chk("bp_stall", 128'(stall_req),
          128'((i + 1) >= (FD - PS)));
    end
    put(FD, 2, 1'b0);
    step();
    output_valid = 1'b0;
    chk("bp_overflow", 128'(overflow_err), 128'(1));
    chk("bp_head", 128'(out_data), 128'(2 * 256));
    put(FD + 1, 2, 1'b1);
    out_ready = 1'b1;
    step();
    output_valid = 1'b0;
    p0 = pops;
    k = 0;
    while (out_valid && k < 40) begin
      step();
      k++;
    end
    chk("full_pushpop_occ", 128'(pops - p0), 128'(FD));
    for (i = FD + 2; i < TOT; i++) begin
      put(i, 2, 1'b1);
      step();
    end
    output_valid = 1'b0;
    wait_done("bp");
    chk("bp_overflow_sticky", 128'(overflow_err), 128'(1));
    repeat (2) step();
    chk("bp_done_once", 128'(done_cnt), 128'(2));

    // Pointer wrap with random ready; pushes honour stall.
    do_start();
    i = 0;
    k = 0;
    while (i < TOT && k < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!stall_req) begin
        put(i, 3, 1'b1);
        i++;
      end else begin
        output_valid = 1'b0;
      end
      step();
      k++;
    end
    output_valid = 1'b0;
    out_ready = 1'b1;
    chk("wrap_all_sent", 128'(i), 128'(TOT));
    wait_done("wrap");
    chk("wrap_overflow", 128'(overflow_err), 128'(0));
    repeat (2) step();
    chk("wrap_done_once", 128'(done_cnt), 128'(3));

    // Stray sample in IDLE, then restart clears it.
    out_ready = 1'b0;
    put(0, 9, 1'b0);
    step();
    output_valid = 1'b0;
    chk("stray_set", 128'(stray_err), 128'(1));
    chk("stray_no_entry", 128'(out_valid), 128'(0));
    step();
    chk("stray_no_entry2", 128'(out_valid), 128'(0));
    chk("stray_idle", 128'(busy), 128'(0));
    put(0, 9, 1'b0);
    do_start();
    output_valid = 1'b0;
    chk("stray_cleared", 128'(stray_err), 128'(0));
    chk("restart_empty", 128'(out_valid), 128'(0));

    // Reset with three entries buffered.
    for (i = 0; i < 3; i++) begin
      put(i, 4, 1'b1);
      step();
    end
    output_valid = 1'b0;
    chk("pre_rst_valid", 128'(out_valid), 128'(1));
    rst_in = 1'b1;
    sb.delete();
    step();
    chk("rst_mid_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_done", 128'(layer_done), 128'(0));
    rst_in = 1'b0;
    repeat (2) step();
    chk("rst_mid_no_pulse", 128'(done_cnt), 128'(3));

    // Fresh layer after reset.
    do_start();
    run_layer(5);
    wait_done("fresh");
    chk("fresh_errs", 128'({overflow_err, stray_err}), 128'(0));
    repeat (2) step();
    chk("fresh_done_once", 128'(done_cnt), 128'(4));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
